// File: rtl/mem_resp_pkg.sv
// Shared types, FSM encoding and access-error check for the unified memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  // Responder FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // One request as captured from the request channel
  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  // An access is rejected when it is not word aligned or falls beyond the last word.
  function automatic logic access_err(input logic [31:0] addr, input int unsigned depth_words);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port word memory with per-byte write enables and a registered read port.
// Latency: write and read both take effect on the access edge; read data is registered.
// Backpressure: none; the caller issues at most one access per cycle.
module sram_1rw
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Byte-masked store; the array itself is never reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Capture the pre-write word on a load; stores and rejected accesses return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (acc_i) begin
      rdata_q <= (en_i && !we_i) ? mem_q[idx_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/unified_mem_responder.sv
// Unified instruction/data memory responder with programmable wait states and error responses.
// Latency: request accepted at edge T shows rsp_valid from edge T+WAIT_STATES (sampled at T+WAIT_STATES+1).
// Backpressure: one outstanding request; req_ready stays low until the response handshake completes.
module unified_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       hold_q, hold_d;
  logic       err_q, err_d;

  req_t       req_in;
  req_t       acc_req;
  logic       accept;
  logic       access;
  logic       acc_err;

  // Bundle the request channel fields into one record
  always_comb begin
    req_in       = '0;
    req_in.we    = req_we;
    req_in.addr  = req_addr;
    req_in.wdata = req_wdata;
    req_in.wstrb = req_wstrb;
  end

  assign accept = (state_q == ST_IDLE) && req_valid;

  // Without wait states the access happens in the accept cycle, straight from the bus;
  // otherwise it happens on the last WAIT cycle from the holding registers.
  assign access  = (WAIT_STATES == 0) ? accept : ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign acc_req = (WAIT_STATES == 0) ? req_in : hold_q;
  assign acc_err = access_err(acc_req.addr, DEPTH_WORDS);

  // Next-state, wait counter and request/error holding logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = access ? acc_err : err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          hold_d = req_in;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // The array has no reset of its own, so memory enable is also gated by reset
  // to keep a zero-wait-state request from writing while reset is held.
  sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk     (clk),
    .rst_n   (reset),
    .acc_i   (access),
    .en_i    (access && !acc_err && reset),
    .we_i    (acc_req.we),
    .idx_i   (acc_req.addr[AW+1:2]),
    .wdata_i (acc_req.wdata),
    .wstrb_i (acc_req.wstrb),
    .rdata_o (rsp_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = err_q;

endmodule
